// File: rtl/seq_div_unit.sv
// Multicycle signed restoring divider: quotient on LO, remainder on HI.
// One quotient bit per cycle; sign correction in a separate FIX cycle.
module seq_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             div_start,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             div_end,
    output logic             div_0_exception,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StCalc, StFix, StDone, StZero} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] quo_q, rem_q, dvs_q, hi_q, lo_q;
    logic [CntW-1:0]  cnt_q;
    logic             sign_q_q, sign_r_q, div_end_q, div0_q;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, trial;

    // Operand magnitudes (modulo 2^WIDTH, so the most negative value maps to itself)
    always_comb begin
        a_abs = A[WIDTH-1] ? (~A + 1'b1) : A;
        b_abs = B[WIDTH-1] ? (~B + 1'b1) : B;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    state_d = (B == '0) ? StZero : StCalc;
                end
            end
            StCalc:  if (cnt_q == '0) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            StZero:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            div_end_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            div_end_q <= 1'b0;
            div0_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (div_start) begin
                        if (B == '0) begin
                            div0_q <= 1'b1;
                        end else begin
                            quo_q    <= a_abs;
                            dvs_q    <= b_abs;
                            rem_q    <= '0;
                            sign_q_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            sign_r_q <= A[WIDTH-1];
                            cnt_q    <= CntMax;
                        end
                    end
                end
                StCalc: begin
                    quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt_q <= cnt_q - 1'b1;
                end
                StFix: begin
                    // Quotient truncates toward zero, remainder follows the dividend
                    quo_q <= sign_q_q ? (~quo_q + 1'b1) : quo_q;
                    rem_q <= sign_r_q ? (~rem_q + 1'b1) : rem_q;
                end
                StDone: begin
                    lo_q      <= quo_q;
                    hi_q      <= rem_q;
                    div_end_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output drive
    always_comb begin
        HI              = hi_q;
        LO              = lo_q;
        div_end         = div_end_q;
        div_0_exception = div0_q;
        busy            = (state_q != StIdle);
    end

endmodule
